fancy_count_ctrl: RTL and testbench

FANCY_COUNT_CTRL -- requirements
Module: fancy_count_ctrl

---
 rtl/fancy_count_ctrl.sv | 132 +++++++++++++
 tb/tb_fancy_count_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fancy_count_ctrl.sv
// rtl/fancy_count_ctrl.sv - start/stop/pause counter with even-value dwell and optional looping
module fancy_count_ctrl #(
  parameter int CNT_W   = 3,
  parameter int DWELL_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               loop,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [CNT_W-1:0]   limit,
  output logic [CNT_W-1:0]   cnt,
  output logic               busy,
  output logic               paused,
  output logic               done,
  output logic               wrap
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DWELL_W-1:0]   dcnt_q, dcnt_d;
  logic [DWELL_W-1:0]   dwell_cfg_q, dwell_cfg_d;
  logic [CNT_W-1:0]     limit_cfg_q, limit_cfg_d;
  logic                 loop_cfg_q, loop_cfg_d;
  logic                 busy_q, busy_d;
  logic                 paused_q, paused_d;
  logic                 done_q, done_d;
  logic                 wrap_q, wrap_d;
  logic                 hold_expired;

  // Odd values hold one cycle; even values hold until dcnt reaches the latched dwell.
  assign hold_expired = cnt_q[0] || (dcnt_q == dwell_cfg_q);

  // Next-state and output decode; stop beats pause, pause beats advancing.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dcnt_d      = dcnt_q;
    dwell_cfg_d = dwell_cfg_q;
    limit_cfg_d = limit_cfg_q;
    loop_cfg_d  = loop_cfg_q;
    done_d      = 1'b0;
    wrap_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          dwell_cfg_d = (dwell == '0) ? DWELL_W'(1) : dwell;
          limit_cfg_d = limit;
          loop_cfg_d  = loop;
          cnt_d       = '0;
          dcnt_d      = DWELL_W'(1);
          state_d     = RUN;
        end
      end
      RUN, PAUSE: begin
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
          dcnt_d  = DWELL_W'(1);
        end else if (pause) begin
          state_d = PAUSE;
        end else begin
          // Leaving PAUSE takes a normal step on the same edge so that the
          // sequence stretches by exactly the number of paused cycles.
          state_d = RUN;
          if (!hold_expired) begin
            dcnt_d = dcnt_q + DWELL_W'(1);
          end else if (cnt_q != limit_cfg_q) begin
            cnt_d  = cnt_q + CNT_W'(1);
            dcnt_d = DWELL_W'(1);
          end else if (loop_cfg_q) begin
            cnt_d  = '0;
            dcnt_d = DWELL_W'(1);
            wrap_d = 1'b1;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        dcnt_d  = DWELL_W'(1);
      end
    endcase
    busy_d   = (state_d != IDLE);
    paused_d = (state_d == PAUSE);
  end

  // State, configuration and registered outputs; reset takes effect immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dcnt_q      <= DWELL_W'(1);
      dwell_cfg_q <= DWELL_W'(1);
      limit_cfg_q <= '1;
      loop_cfg_q  <= 1'b0;
      busy_q      <= 1'b0;
      paused_q    <= 1'b0;
      done_q      <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dcnt_q      <= dcnt_d;
      dwell_cfg_q <= dwell_cfg_d;
      limit_cfg_q <= limit_cfg_d;
      loop_cfg_q  <= loop_cfg_d;
      busy_q      <= busy_d;
      paused_q    <= paused_d;
      done_q      <= done_d;
      wrap_q      <= wrap_d;
    end
  end

  assign cnt    = cnt_q;
  assign busy   = busy_q;
  assign paused = paused_q;
  assign done   = done_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_fancy_count_ctrl.sv
// tb/tb_fancy_count_ctrl.sv - self-checking bench for fancy_count_ctrl
module tb_fancy_count_ctrl;

  localparam int CNT_W   = 3;
  localparam int DWELL_W = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               pause = 1'b0;
  logic               loop = 1'b0;
  logic [DWELL_W-1:0] dwell = '0;
  logic [CNT_W-1:0]   limit = '0;
  logic [CNT_W-1:0]   cnt;
  logic               busy;
  logic               paused;
  logic               done;
  logic               wrap;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  int exp1[11] = '{0, 0, 0, 1, 2, 2, 2, 3, 4, 4, 4};
  int done_at;

  fancy_count_ctrl #(.CNT_W(CNT_W), .DWELL_W(DWELL_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .stop   (stop),
    .pause  (pause),
    .loop   (loop),
    .dwell  (dwell),
    .limit  (limit),
    .cnt    (cnt),
    .busy   (busy),
    .paused (paused),
    .done   (done),
    .wrap   (wrap)
  );

  always #5 clk = ~clk;

  // Reference model: the whole count sequence is a list of values, one entry per cycle.
  int q[$];
  int m_cnt    = 0;
  bit m_busy   = 0;
  bit m_paused = 0;
  bit m_done   = 0;
  bit m_wrap   = 0;
  bit m_loop   = 0;
  int m_limit  = 0;
  int m_dwell  = 1;

  function automatic void build_seq();
    q.delete();
    for (int k = 0; k <= m_limit; k++) begin
      for (int r = 0; r < ((k % 2 == 0) ? m_dwell : 1); r++) q.push_back(k);
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    m_cnt = 0; m_busy = 0; m_paused = 0; m_done = 0; m_wrap = 0;
  endfunction

  function automatic void model_step();
    m_done = 0;
    m_wrap = 0;
    if (!m_busy) begin
      if (start && !stop) begin
        m_dwell = (dwell == 0) ? 1 : int'(dwell);
        m_limit = int'(limit);
        m_loop  = loop;
        build_seq();
        m_cnt  = q.pop_front();
        m_busy = 1;
      end
    end else if (stop) begin
      q.delete();
      m_cnt = 0; m_busy = 0; m_paused = 0;
    end else if (pause) begin
      m_paused = 1;
    end else begin
      m_paused = 0;
      if (q.size() > 0) begin
        m_cnt = q.pop_front();
      end else if (m_loop) begin
        build_seq();
        m_cnt  = q.pop_front();
        m_wrap = 1;
      end else begin
        m_done = 1;
        m_busy = 0;
      end
    end
  endfunction

  always @(posedge clk) if (!rst) model_step();
  always @(posedge rst) model_reset();

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("cmp_cnt", 32'(cnt), 32'(m_cnt));
      check("cmp_busy", 32'(busy), 32'(m_busy));
      check("cmp_paused", 32'(paused), 32'(m_paused));
      check("cmp_done", 32'(done), 32'(m_done));
      check("cmp_wrap", 32'(wrap), 32'(m_wrap));
    end
  end

  // Present a one-cycle start; returns at the negedge after the start edge.
  task automatic start_seq(input int d, input int l, input bit lp);
    dwell = DWELL_W'(d);
    limit = CNT_W'(l);
    loop  = lp;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    check("rst_cnt", 32'(cnt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_paused", 32'(paused), 0);
    check("rst_done", 32'(done), 0);
    check("rst_wrap", 32'(wrap), 0);
    rst = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);

    // Basic sequence with dwell 3 up to 4
    start_seq(3, 4, 0);
    for (int i = 0; i < 11; i++) begin
      check($sformatf("s1_cnt%0d", i), 32'(cnt), 32'(exp1[i]));
      check("s1_nodone", 32'(done), 0);
      @(negedge clk);
    end
    check("s1_done", 32'(done), 1);
    check("s1_busy_end", 32'(busy), 0);
    check("s1_cnt_end", 32'(cnt), 4);
    @(negedge clk);
    check("s1_done_pulse", 32'(done), 0);
    check("s1_cnt_hold", 32'(cnt), 4);

    // Looping 0,1,2 with wrap on each restart
    start_seq(1, 2, 1);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("s2_cnt%0d", i), 32'(cnt), 32'(i % 3));
      check($sformatf("s2_wrap%0d", i), 32'(wrap), 32'((i > 0 && i % 3 == 0) ? 1 : 0));
      check("s2_nodone", 32'(done), 0);
      @(negedge clk);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("s2_stop_busy", 32'(busy), 0);
    check("s2_stop_cnt", 32'(cnt), 0);

    // Pause five cycles in the middle of the cnt=2 dwell
    start_seq(3, 4, 0);
    done_at = -1;
    for (int i = 0; i < 40 && done_at < 0; i++) begin
      if (done) done_at = i;
      if (i == 5) check("s3_mid_dwell", 32'(cnt), 2);
      if (i >= 6 && i <= 10) begin
        check($sformatf("s3_paused%0d", i), 32'(paused), 1);
        check($sformatf("s3_frozen%0d", i), 32'(cnt), 2);
      end
      if (i == 5) pause = 1'b1;
      if (i == 10) pause = 1'b0;
      @(negedge clk);
    end
    check("s3_done_at", 32'(done_at), 16);

    // Stop at cnt=3, then start together with stop in IDLE
    start_seq(1, 5, 0);
    repeat (3) @(negedge clk);
    check("s4_cnt3", 32'(cnt), 3);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("s4_stop_busy", 32'(busy), 0);
    check("s4_stop_cnt", 32'(cnt), 0);
    check("s4_stop_nodone", 32'(done), 0);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check("s4_startstop_busy", 32'(busy), 0);
    @(negedge clk);
    check("s4_startstop_busy2", 32'(busy), 0);

    // Dwell 0 acts as 1; a start while busy must not reload config
    start_seq(0, 3, 0);
    done_at = -1;
    for (int i = 0; i < 20 && done_at < 0; i++) begin
      if (done) begin
        done_at = i;
        check("s5_cnt_end", 32'(cnt), 3);
      end
      if (i == 1) begin
        start = 1'b1; dwell = 3'd7; limit = 3'd1; loop = 1'b1;
      end
      if (i == 2) start = 1'b0;
      @(negedge clk);
    end
    check("s5_done_at", 32'(done_at), 4);
    loop = 1'b0;

    // Asynchronous reset between clock edges
    start_seq(2, 6, 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("s6_async_cnt", 32'(cnt), 0);
    check("s6_async_busy", 32'(busy), 0);
    check("s6_async_done", 32'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    start_seq(1, 2, 0);
    done_at = -1;
    for (int i = 0; i < 20 && done_at < 0; i++) begin
      if (done) done_at = i;
      @(negedge clk);
    end
    check("s6_done_at", 32'(done_at), 3);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
